// File: rtl/demux16_router.sv
// ============================================================================
// demux16_router : buffered 1-to-2 word demultiplexer with per-output FIFOs
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module demux16_router #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  output logic [WIDTH-1:0] out_a,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Index 0 is output A, index 1 is output B
  logic             w_full      [2];
  logic             w_empty     [2];
  logic             w_push      [2];
  logic             w_pop       [2];
  logic             w_out_ready [2];
  logic [WIDTH-1:0] w_head      [2];
  logic [CNT_W-1:0] w_cnt       [2];

  assign w_out_ready[0] = out_a_ready;
  assign w_out_ready[1] = out_b_ready;

  // Depends only on sel and pointer-derived full flags, never on the handshakes
  assign in_ready = sel ? !w_full[1] : !w_full[0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW:0]      r_wptr;
      logic [AW:0]      r_rptr;
      logic [CNT_W-1:0] r_cnt;

      assign w_empty[gi] = (r_wptr == r_rptr);
      assign w_full[gi]  = (r_wptr[AW] != r_rptr[AW]) &&
                           (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
      assign w_push[gi]  = in_valid && in_ready && (sel == 1'(gi));
      assign w_pop[gi]   = !w_empty[gi] && w_out_ready[gi];
      assign w_head[gi]  = w_empty[gi] ? '0 : r_mem[r_rptr[AW-1:0]];
      assign w_cnt[gi]   = r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
          end
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push[gi]) begin
            r_mem[r_wptr[AW-1:0]] <= in_data;
            r_wptr                <= r_wptr + PTR_ONE;
          end
          if (w_pop[gi]) begin
            r_rptr <= r_rptr + PTR_ONE;
            r_cnt  <= r_cnt + CNT_ONE;
          end
        end
      end
    end
  endgenerate

  assign out_a       = w_head[0];
  assign out_a_valid = !w_empty[0];
  assign cnt_a       = w_cnt[0];
  assign out_b       = w_head[1];
  assign out_b_valid = !w_empty[1];
  assign cnt_b       = w_cnt[1];

endmodule

`default_nettype wire

// File: tb/tb_demux16_router.sv
// ============================================================================
// tb_demux16_router : directed + random scoreboard bench for demux16_router
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_demux16_router;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sel;
  logic [WIDTH-1:0] out_a;
  logic             out_a_valid;
  logic             out_a_ready;
  logic [WIDTH-1:0] out_b;
  logic             out_b_valid;
  logic             out_b_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  demux16_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .out_a(out_a), .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_b(out_b), .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [CNT_W-1:0] exp_cnt_a = '0;
  logic [CNT_W-1:0] exp_cnt_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs to the scoreboard, then records this cycle's handshakes
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      exp_cnt_a = '0;
      exp_cnt_b = '0;
      chk("rst_a_valid", 32'(out_a_valid), 32'd0);
      chk("rst_out_a",   32'(out_a),       32'd0);
      chk("rst_cnt_a",   32'(cnt_a),       32'd0);
      chk("rst_b_valid", 32'(out_b_valid), 32'd0);
      chk("rst_out_b",   32'(out_b),       32'd0);
      chk("rst_cnt_b",   32'(cnt_b),       32'd0);
    end else begin
      chk("a_valid", 32'(out_a_valid), 32'(qa.size() != 0));
      chk("out_a",   32'(out_a), (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
      chk("b_valid", 32'(out_b_valid), 32'(qb.size() != 0));
      chk("out_b",   32'(out_b), (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
      chk("cnt_a",   32'(cnt_a), 32'(exp_cnt_a));
      chk("cnt_b",   32'(cnt_b), 32'(exp_cnt_b));
      chk("in_ready", 32'(in_ready),
          32'(sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH)));
      if (out_a_valid && out_a_ready && qa.size() != 0) begin
        void'(qa.pop_front());
        exp_cnt_a = exp_cnt_a + 1'b1;
      end
      if (out_b_valid && out_b_ready && qb.size() != 0) begin
        void'(qb.pop_front());
        exp_cnt_b = exp_cnt_b + 1'b1;
      end
      if (in_valid && in_ready) begin
        if (sel) qb.push_back(in_data);
        else     qa.push_back(in_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic s);
    int n;
    in_data  = d;
    sel      = s;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid    = 1'b0;
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
      cyc();
      n++;
    end
    cyc();
    chk("drain_empty", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    sel         = 1'b0;
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Mid-stream reset with two words parked in A
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    @(negedge clk);
    chk("pre_rst_a_valid", 32'(out_a_valid), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Steer
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
    send(16'h1234, 1'b0);
    send(16'hABCD, 1'b1);
    repeat (3) cyc();
    @(negedge clk);
    chk("steer_cnt_a", 32'(cnt_a), 32'd1);
    chk("steer_cnt_b", 32'(cnt_b), 32'd1);

    // Back-pressure on A; B still flows
    cyc();
    out_a_ready = 1'b0;
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    sel = 1'b0;
    @(negedge clk);
    chk("bp_ready_sel0", 32'(in_ready), 32'd0);
    cyc();
    sel = 1'b1;
    @(negedge clk);
    chk("bp_ready_sel1", 32'(in_ready), 32'd1);
    cyc();
    send(16'h00B0, 1'b1);
    repeat (2) cyc();
    @(negedge clk);
    chk("bp_cnt_b", 32'(cnt_b), 32'd2);
    chk("bp_a_held", 32'(out_a), 32'h0001);

    // Full + pop: push refused this cycle, accepted the next
    cyc();
    out_a_ready = 1'b1;
    in_data     = 16'h0003;
    sel         = 1'b0;
    in_valid    = 1'b1;
    @(negedge clk);
    chk("full_pop_ready", 32'(in_ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("freed_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("fp_cnt_a", 32'(cnt_a), 32'd4);

    // Counter wrap on B
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    send(16'h5A5A, 1'b0);
    for (int i = 0; i < 256; i++) send(16'(i), 1'b1);
    drain();
    @(negedge clk);
    chk("wrap_cnt_b", 32'(cnt_b), 32'd0);
    chk("wrap_cnt_a", 32'(cnt_a), 32'd1);

    // Random traffic
    cyc();
    for (int i = 0; i < 10000; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      sel         = 1'($urandom_range(0, 1));
      in_data     = 16'($urandom);
      out_a_ready = ($urandom_range(0, 3) != 0);
      out_b_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
